// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch button controller: state encoding
// and its width, used by the control FSM and visible on o_state.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

endpackage : stopwatch_pkg

// File: rtl/btn_edge_det.sv
// Rising-edge detector for one debounced button level.
// The previous-level register resets to 1, so a button already held when
// reset is released produces no edge until it is released and pressed again.
module btn_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic prev_q;

  // Track last sampled level; reset high to suppress edges from held buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= i_level;
    end
  end

  assign o_rise = i_level & ~prev_q;

endmodule : btn_edge_det

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch button controller: turns the debounced run/stop and clear
// levels into press events (rising edges, run/stop long press) and runs
// the STOP/RUN/CLEAR control FSM. All outputs are decoded from registers,
// so there is no combinational path from the buttons to the outputs.
// The buttons are plain levels sampled every clock; there is no handshake.
module stopwatch_btn_ctrl
  import stopwatch_pkg::*;
#(
  parameter int LONG_PRESS_CYCLES = 100_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_btn_run_stop,
  input  logic               i_btn_clear,
  output logic [STATE_W-1:0] o_state,
  output logic               o_run,
  output logic               o_clear,
  output logic               o_long_press
);

  localparam int             CW       = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_SAT  = CW'(LONG_PRESS_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(LONG_PRESS_CYCLES - 1);

  logic          rise_run_stop;
  logic          rise_clear;
  logic [CW-1:0] hold_cnt_q;
  logic          long_event;
  logic          long_press_q;
  state_t        state_q;
  state_t        state_d;

  btn_edge_det u_edge_run_stop (
    .clk     (clk),
    .reset   (reset),
    .i_level (i_btn_run_stop),
    .o_rise  (rise_run_stop)
  );

  btn_edge_det u_edge_clear (
    .clk     (clk),
    .reset   (reset),
    .i_level (i_btn_clear),
    .o_rise  (rise_clear)
  );

  // Count consecutive high samples of run/stop, saturating so a long hold
  // fires only once. Resetting to the saturated value keeps a button held
  // through reset from ever producing a long press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q <= CNT_SAT;
    end else if (!i_btn_run_stop) begin
      hold_cnt_q <= '0;
    end else if (hold_cnt_q != CNT_SAT) begin
      hold_cnt_q <= hold_cnt_q + 1'b1;
    end
  end

  // The LONG_PRESS_CYCLES-th consecutive high sample.
  assign long_event = i_btn_run_stop && (hold_cnt_q == CNT_LAST);

  // Register the long-press pulse so it is high for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_press_q <= 1'b0;
    end else begin
      long_press_q <= long_event;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: long press overrides everything; clear beats run in
  // STOP; clear is ignored while running; CLEAR lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    if (long_event) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (rise_clear) begin
            state_d = ST_CLEAR;
          end else if (rise_run_stop) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (rise_run_stop) begin
            state_d = ST_STOP;
          end
        end
        ST_CLEAR: begin
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_STOP;
        end
      endcase
    end
  end

  assign o_state      = state_q;
  assign o_run        = (state_q == ST_RUN);
  assign o_clear      = (state_q == ST_CLEAR);
  assign o_long_press = long_press_q;

endmodule : stopwatch_btn_ctrl

// File: tb/tb_stopwatch_btn_ctrl.sv
// Bench for stopwatch_btn_ctrl with LONG_PRESS_CYCLES = 8.
// The driver applies one input vector per cycle on the falling edge and
// queues the hand-computed outputs expected after the next rising edge;
// the monitor pops and compares just after each rising edge.
module tb_stopwatch_btn_ctrl;

  localparam int LPC = 8;

  localparam logic [1:0] S_STOP  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  logic       clk;
  logic       reset;
  logic       btn_run_stop;
  logic       btn_clear;
  logic [1:0] o_state;
  logic       o_run;
  logic       o_clear;
  logic       o_long_press;

  // expected {state[1:0], run, clear, long_press}
  logic [4:0] exp_q[$];
  int         tag_q[$];
  int         n_vec;
  int         n_err;
  int         vec_id;

  stopwatch_btn_ctrl #(
    .LONG_PRESS_CYCLES (LPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_btn_run_stop (btn_run_stop),
    .i_btn_clear    (btn_clear),
    .o_state        (o_state),
    .o_run          (o_run),
    .o_clear        (o_clear),
    .o_long_press   (o_long_press)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d expected items pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] mk_exp(input logic [1:0] st, input logic lp);
    return {st, (st == S_RUN), (st == S_CLEAR), lp};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got state=%0d run=%b clear=%b long=%b, expected state=%0d run=%b clear=%b long=%b",
               name, got[4:3], got[2], got[1], got[0], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // driver: one vector per cycle
  task automatic cyc(input logic rst, input logic rs, input logic clr,
                     input logic [1:0] st, input logic lp);
    @(negedge clk);
    reset        = rst;
    btn_run_stop = rs;
    btn_clear    = clr;
    vec_id++;
    exp_q.push_back(mk_exp(st, lp));
    tag_q.push_back(vec_id);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      int         t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check($sformatf("vec%0d", t), {o_state, o_run, o_clear, o_long_press}, e);
    end
  end

  initial begin
    n_vec        = 0;
    n_err        = 0;
    vec_id       = 0;
    reset        = 1'b1;
    btn_run_stop = 1'b0;
    btn_clear    = 1'b0;

    // reset, then release with both buttons low
    repeat (3) cyc(1, 0, 0, S_STOP, 0);
    repeat (2) cyc(0, 0, 0, S_STOP, 0);

    // short run/stop presses: start, then stop, no long press
    repeat (3) cyc(0, 1, 0, S_RUN, 0);
    repeat (10) cyc(0, 0, 0, S_RUN, 0);
    repeat (3) cyc(0, 1, 0, S_STOP, 0);
    repeat (3) cyc(0, 0, 0, S_STOP, 0);

    // clear in STOP: one-cycle CLEAR, then STOP
    cyc(0, 0, 1, S_CLEAR, 0);
    cyc(0, 0, 1, S_STOP, 0);
    cyc(0, 0, 0, S_STOP, 0);

    // clear while running is ignored
    cyc(0, 1, 0, S_RUN, 0);
    cyc(0, 0, 0, S_RUN, 0);
    cyc(0, 0, 1, S_RUN, 0);
    cyc(0, 0, 1, S_RUN, 0);
    cyc(0, 0, 0, S_RUN, 0);
    cyc(0, 1, 0, S_STOP, 0);
    repeat (2) cyc(0, 0, 0, S_STOP, 0);

    // long press from STOP: RUN, CLEAR + pulse on 8th sample, STOP, no retrigger
    for (int i = 1; i <= 20; i++) begin
      if (i < LPC)       cyc(0, 1, 0, S_RUN, 0);
      else if (i == LPC) cyc(0, 1, 0, S_CLEAR, 1);
      else               cyc(0, 1, 0, S_STOP, 0);
    end
    repeat (2) cyc(0, 0, 0, S_STOP, 0);

    // simultaneous rises in STOP: clear wins, run never starts
    cyc(0, 1, 1, S_CLEAR, 0);
    cyc(0, 1, 1, S_STOP, 0);
    repeat (2) cyc(0, 0, 0, S_STOP, 0);

    // run/stop held through reset: no edge, no long press after release
    cyc(0, 1, 0, S_RUN, 0);
    repeat (2) cyc(1, 1, 0, S_STOP, 0);
    repeat (10) cyc(0, 1, 0, S_STOP, 0);
    repeat (2) cyc(0, 0, 0, S_STOP, 0);
    cyc(0, 1, 0, S_RUN, 0);
    cyc(0, 0, 0, S_RUN, 0);

    // asynchronous reset while running, away from any clock edge
    @(posedge clk);
    #3;
    check("run_before_async_reset", {o_state, o_run, o_clear, o_long_press}, mk_exp(S_RUN, 0));
    reset = 1'b1;
    #1;
    check("async_reset_in_run", {o_state, o_run, o_clear, o_long_press}, mk_exp(S_STOP, 0));
    repeat (2) cyc(0, 0, 0, S_STOP, 0);
    cyc(0, 1, 0, S_RUN, 0);
    cyc(0, 0, 0, S_RUN, 0);

    // drain
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending items, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_stopwatch_btn_ctrl

// File: doc/stopwatch_btn_ctrl.md
Name: stopwatch_btn_ctrl

Overview:
- Consumer end of the debounce path. Takes the two clean, debounced button levels that the debounce blocks produce.
- Decodes them into press events: rising edges and a long-press on run/stop.
- Drives the stopwatch run/stop/clear control FSM that feeds the time counter and display logic.
- Moore outputs; one clock domain shared with the debounce blocks.

Parameters:
- LONG_PRESS_CYCLES, default 100_000_000, number of consecutive high samples of i_btn_run_stop that makes a long press (1 s at 100 MHz). Must be >= 2. Simulation uses 8.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- i_btn_run_stop  in  1  debounced run/stop button level, synchronous to clk.
- i_btn_clear  in  1  debounced clear button level, synchronous to clk.
- o_state  out  2  current FSM state: 0=STOP, 1=RUN, 2=CLEAR.
- o_run  out  1  high while state==RUN; time counter enable.
- o_clear  out  1  high while state==CLEAR; time counter synchronous clear.
- o_long_press  out  1  one-cycle pulse when a run/stop long press is detected.

Behaviour:
- Reset values: state=STOP, o_run=0, o_clear=0, o_long_press=0. Previous-level registers = 1. Hold counter = LONG_PRESS_CYCLES (saturated).
- Consequence of reset values: a button held through reset release generates no edge and no long press until it has been released and pressed again.
- Edge detect: rise = i_btn & ~prev. prev <= i_btn on every clk.
- Latency: the first high sample at edge k updates state at edge k, so outputs change 1 clk after the input rises.
- Hold counter, width $clog2(LONG_PRESS_CYCLES+1):
  - i_btn_run_stop low -> 0.
  - High and count != LONG_PRESS_CYCLES -> count+1.
  - Otherwise hold (saturate).
- Long event: i_btn_run_stop high and count == LONG_PRESS_CYCLES-1, i.e. the LONG_PRESS_CYCLES-th consecutive high sample. Fires once per press. o_long_press is registered, high for exactly the following cycle.
- Transitions, in priority order:
  - Any state, long event -> CLEAR.
  - STOP:
    - rise_clear -> CLEAR.
    - else rise_run_stop -> RUN.
    - else stay.
  - RUN:
    - rise_run_stop -> STOP.
    - rise_clear ignored (no clear while running).
  - CLEAR: unconditionally -> STOP after exactly one cycle. Edges arriving in this cycle are discarded.
- Simultaneous rising edges in STOP: clear wins, then STOP; run does not start.
- A long press that starts in STOP therefore runs STOP -> RUN (on the edge) -> CLEAR -> STOP. The counter stays saturated until release, so there is no retrigger.
- Releasing or re-pressing run/stop during the CLEAR cycle has no effect beyond updating prev and the counter.
- Reset asserted mid-operation clears immediately and asynchronously to the reset values, regardless of button levels.
- Outputs are decoded from registered state only; no combinational path from inputs to outputs.

Decomposition:
- Package stopwatch_pkg:
  - State encoding constants ST_STOP=2'd0, ST_RUN=2'd1, ST_CLEAR=2'd2.
  - State width constant.
- Sub-module btn_edge_det (clk, reset, i_level, o_rise) with reset-to-1 prev register. Instantiated once per button.
- The hold counter and FSM stay in the top.

Test Plan (clk 10 ns, LONG_PRESS_CYCLES=8):
- Reset release with both buttons low -> o_state=0, o_run=0, o_clear=0, o_long_press=0.
- run_stop high 3 cycles then low; repeat after 10 cycles -> o_run=1 one clk after the first rise, o_run=0 one clk after the second rise, no o_long_press.
- In STOP, clear high 2 cycles -> o_clear=1 for exactly 1 cycle, then o_state=0. In RUN, clear press -> o_run remains 1, o_clear stays 0.
- run_stop held 20 cycles from STOP -> RUN after 1 clk. On the 8th high sample, o_long_press pulses 1 cycle and o_state=2 for 1 cycle, then 0. No further events until release.
- Both buttons rise on the same clock in STOP -> o_state=2 for 1 cycle, then 0; o_run never asserts.
- Hold run_stop high through reset assertion and release, then keep it high 10 cycles -> no state change and no o_long_press. Release, then press -> RUN. Additionally, assert reset while in RUN -> o_run=0 immediately, asynchronously.
